bank_access_scheduler: RTL and testbench

BANK_ACCESS_SCHEDULER -- requirements
Module: bank_access_scheduler

---
 rtl/bank_access_scheduler_pkg.sv | 11 +
 rtl/bank_access_scheduler_picker.sv | 40 ++++
 rtl/bank_access_scheduler.sv | 107 ++++++++++
 tb/tb_bank_access_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_access_scheduler_pkg.sv
// Shared types and default geometry for the bank access scheduler.
package bank_access_scheduler_pkg;
    localparam int DEFAULT_SIZE = 8;
    localparam int DEFAULT_K    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bank_access_scheduler_picker.sv
// rr_bank_picker: combinational round-robin grant of pending requesters,
// one requester per bank per cycle, scanning from rr_ptr.
module rr_bank_picker
    import bank_access_scheduler_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int K    = DEFAULT_K,
    parameter int BIT  = $clog2(SIZE),
    parameter int PW   = (K > 1) ? $clog2(K) : 1
) (
    input  logic [K-1:0]     pending,
    input  logic [PW-1:0]    rr_ptr,
    input  logic [K*BIT-1:0] addr,
    output logic [K-1:0]     grant,
    output logic [SIZE-1:0]  bank_en
);
    logic [BIT-1:0] addr_arr [K];

    for (genvar i = 0; i < K; i++) begin : g_unpack
        assign addr_arr[i] = addr[BIT*i +: BIT];
    end

    // bank_en doubles as the "bank already claimed this cycle" mask
    always_comb begin
        logic [PW-1:0]   idx;
        logic [SIZE-1:0] onehot;
        idx     = '0;
        onehot  = '0;
        grant   = '0;
        bank_en = '0;
        for (int j = 0; j < K; j++) begin
            idx    = PW'((int'(rr_ptr) + j) % K);
            onehot = SIZE'(1) << addr_arr[idx];
            if (pending[idx] && (onehot != '0) && ((bank_en & onehot) == '0)) begin
                grant[idx] = 1'b1;
                bank_en    = bank_en | onehot;
            end
        end
    end
endmodule

// File: rtl/bank_access_scheduler.sv
// Batch bank access scheduler: captures K bank addresses and issues them
// over as few cycles as bank conflicts allow, round-robin across batches.
//
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   ISSUE | granting pending requesters, busy=1
//   DONE  | one-cycle completion pulse, done=1
module bank_access_scheduler
    import bank_access_scheduler_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int K    = DEFAULT_K,
    parameter int BIT  = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [K*BIT-1:0] generated_addr,
    output logic             ready,
    output logic             busy,
    output logic [SIZE-1:0]  bank_en,
    output logic [K-1:0]     grant,
    output logic [K-1:0]     dropped,
    output logic             done
);
    localparam int PW = (K > 1) ? $clog2(K) : 1;

    state_t           state;
    logic [K-1:0]     pending;
    logic [K-1:0]     pending_left;
    logic [K-1:0]     in_valid;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    rr_next;
    logic [K*BIT-1:0] addr_q;

    for (genvar i = 0; i < K; i++) begin : g_valid
        assign in_valid[i] = {1'b0, generated_addr[BIT*i +: BIT]} < (BIT+1)'(SIZE);
    end

    rr_bank_picker #(
        .SIZE (SIZE),
        .K    (K),
        .BIT  (BIT),
        .PW   (PW)
    ) u_picker (
        .pending (pending & {K{state == ISSUE}}),
        .rr_ptr  (rr_ptr),
        .addr    (addr_q),
        .grant   (grant),
        .bank_en (bank_en)
    );

    assign pending_left = pending & ~grant;
    assign rr_next      = (rr_ptr == PW'(K-1)) ? '0 : rr_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            dropped <= '0;
            rr_ptr  <= '0;
            addr_q  <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= generated_addr;
                        pending <= in_valid;
                        dropped <= ~in_valid;
                        ready   <= 1'b0;
                        if (|in_valid) begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    pending <= pending_left;
                    rr_ptr  <= rr_next;
                    if (pending_left == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bank_access_scheduler.sv
// Self-checking bench: directed and random batches on an 8-bank and a
// 6-bank instance, compared against a per-cycle reference model.
module tb_bank_access_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b1, start8 = 1'b0;
    logic [11:0] ga8 = '0;
    logic        ready8, busy8, done8;
    logic [7:0]  be8;
    logic [3:0]  grant8, dropped8;

    logic        rst6 = 1'b1, start6 = 1'b0;
    logic [11:0] ga6 = '0;
    logic        ready6, busy6, done6;
    logic [5:0]  be6;
    logic [3:0]  grant6, dropped6;

    int checks = 0;
    int failures = 0;
    int rr_m8 = 0;
    int rr_m6 = 0;

    bank_access_scheduler dut8 (
        .clk(clk), .rst(rst8), .start(start8), .generated_addr(ga8),
        .ready(ready8), .busy(busy8), .bank_en(be8), .grant(grant8),
        .dropped(dropped8), .done(done8)
    );

    bank_access_scheduler #(.SIZE(6), .K(4), .BIT(3)) dut6 (
        .clk(clk), .rst(rst6), .start(start6), .generated_addr(ga6),
        .ready(ready6), .busy(busy6), .bank_en(be6), .grant(grant6),
        .dropped(dropped6), .done(done6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic g_ready(input int sz);
        return (sz == 8) ? ready8 : ready6;
    endfunction
    function automatic logic g_busy(input int sz);
        return (sz == 8) ? busy8 : busy6;
    endfunction
    function automatic logic g_done(input int sz);
        return (sz == 8) ? done8 : done6;
    endfunction
    function automatic logic [3:0] g_grant(input int sz);
        return (sz == 8) ? grant8 : grant6;
    endfunction
    function automatic logic [3:0] g_dropped(input int sz);
        return (sz == 8) ? dropped8 : dropped6;
    endfunction
    function automatic logic [7:0] g_be(input int sz);
        return (sz == 8) ? be8 : {2'b00, be6};
    endfunction

    task automatic drive(input int sz, input logic st, input logic [11:0] ga);
        if (sz == 8) begin
            start8 = st;
            ga8    = ga;
        end else begin
            start6 = st;
            ga6    = ga;
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b1;
        rst6 = 1'b1;
        drive(8, 1'b0, '0);
        drive(6, 1'b0, '0);
        tick();
        tick();
        rst8 = 1'b0;
        rst6 = 1'b0;
        rr_m8 = 0;
        rr_m6 = 0;
        for (int s = 0; s < 2; s++) begin
            int sz;
            sz = (s == 0) ? 8 : 6;
            checks++;
            if ({g_ready(sz), g_busy(sz), g_done(sz)} !== 3'b100 || g_grant(sz) !== 4'b0 ||
                g_be(sz) !== 8'b0 || g_dropped(sz) !== 4'b0)
                begin
                failures++;
                $display("FAIL reset_outputs size=%0d got rdy/busy/done=%b%b%b grant=%b be=%b dropped=%b expected 100 0000 0 0000",
                         sz, g_ready(sz), g_busy(sz), g_done(sz), g_grant(sz), g_be(sz), g_dropped(sz));
            end
        end
    endtask

    // Drives one batch and checks every cycle until done; noise pulses start
    // during the first ISSUE cycle with unrelated addresses.
    task automatic run_batch(input int sz, input int a0, input int a1, input int a2,
                             input int a3, input bit noise);
        int          a[4];
        logic [3:0]  pend;
        logic [3:0]  exp_drop;
        logic [11:0] ga;
        int          rr;
        int          cyc;
        a  = '{a0, a1, a2, a3};
        rr = (sz == 8) ? rr_m8 : rr_m6;
        ga = '0;
        for (int i = 0; i < 4; i++) begin
            pend[i]     = (a[i] < sz);
            exp_drop[i] = !(a[i] < sz);
            ga[3*i +: 3] = 3'(a[i]);
        end
        checks++;
        if (g_ready(sz) !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_start size=%0d got %b expected 1", sz, g_ready(sz));
        end
        drive(sz, 1'b1, ga);
        tick();
        drive(sz, 1'b0, ga);
        checks++;
        if (g_dropped(sz) !== exp_drop) begin
            failures++;
            $display("FAIL dropped size=%0d got %b expected %b", sz, g_dropped(sz), exp_drop);
        end
        cyc = 0;
        while (pend != 4'b0) begin
            logic [63:0] claimed;
            logic [3:0]  eg;
            if (cyc > 4) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout size=%0d cycles=%0d expected at most 4", sz, cyc);
                break;
            end
            claimed = '0;
            eg      = '0;
            for (int j = 0; j < 4; j++) begin
                int i;
                i = (rr + j) % 4;
                if (pend[i] && !claimed[a[i]]) begin
                    eg[i]         = 1'b1;
                    claimed[a[i]] = 1'b1;
                end
            end
            checks++;
            if (g_busy(sz) !== 1'b1 || g_grant(sz) !== eg || g_be(sz) !== claimed[7:0]) begin
                failures++;
                $display("FAIL issue_cycle size=%0d cyc=%0d got busy=%b grant=%b be=%b expected busy=1 grant=%b be=%b",
                         sz, cyc, g_busy(sz), g_grant(sz), g_be(sz), eg, claimed[7:0]);
            end
            if (noise && cyc == 0)
                drive(sz, 1'b1, 12'($urandom));
            else
                drive(sz, 1'b0, ga);
            pend = pend & ~eg;
            rr   = (rr + 1) % 4;
            cyc++;
            tick();
        end
        drive(sz, 1'b0, ga);
        checks++;
        if (g_done(sz) !== 1'b1 || g_busy(sz) !== 1'b0 || g_ready(sz) !== 1'b0 ||
            g_grant(sz) !== 4'b0 || g_be(sz) !== 8'b0 || g_dropped(sz) !== exp_drop)
            begin
            failures++;
            $display("FAIL done_cycle size=%0d got done=%b busy=%b ready=%b grant=%b be=%b dropped=%b expected 1 0 0 0000 0 %b",
                     sz, g_done(sz), g_busy(sz), g_ready(sz), g_grant(sz), g_be(sz), g_dropped(sz), exp_drop);
        end
        tick();
        checks++;
        if (g_done(sz) !== 1'b0 || g_ready(sz) !== 1'b1 || g_dropped(sz) !== exp_drop) begin
            failures++;
            $display("FAIL after_done size=%0d got done=%b ready=%b dropped=%b expected 0 1 %b",
                     sz, g_done(sz), g_ready(sz), g_dropped(sz), exp_drop);
        end
        if (sz == 8) rr_m8 = rr;
        else         rr_m6 = rr;
    endtask

    task automatic test_directed();
        test_reset();
        run_batch(8, 1, 3, 5, 7, 1'b0);
        test_reset();
        run_batch(8, 2, 2, 2, 2, 1'b0);
        test_reset();
        run_batch(8, 0, 0, 6, 6, 1'b0);
        run_batch(8, 0, 0, 6, 6, 1'b0);
        run_batch(6, 7, 1, 7, 1, 1'b0);
        run_batch(6, 7, 7, 7, 7, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_batch(8, 2, 2, 2, 2, 1'b1);
        run_batch(6, 3, 3, 0, 5, 1'b1);
    endtask

    task automatic test_reset_mid_issue();
        test_reset();
        drive(8, 1'b1, {3'd2, 3'd2, 3'd2, 3'd2});
        tick();
        drive(8, 1'b0, '0);
        for (int c = 0; c < 2; c++) begin
            logic [3:0] eg;
            eg = 4'b0001 << ((rr_m8 + c) % 4);
            checks++;
            if (grant8 !== eg || be8 !== 8'b0000_0100) begin
                failures++;
                $display("FAIL abort_issue cyc=%0d got grant=%b be=%b expected %b 00000100", c, grant8, be8, eg);
            end
            tick();
        end
        rst8 = 1'b1;
        tick();
        rst8  = 1'b0;
        rr_m8 = 0;
        checks++;
        if ({ready8, busy8, done8} !== 3'b100 || grant8 !== 4'b0 || be8 !== 8'b0 || dropped8 !== 4'b0) begin
            failures++;
            $display("FAIL abort_outputs got rdy/busy/done=%b%b%b grant=%b be=%b dropped=%b expected 100 0 0 0",
                     ready8, busy8, done8, grant8, be8, dropped8);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (done8 !== 1'b0 || ready8 !== 1'b1) begin
                failures++;
                $display("FAIL abort_no_done cyc=%0d got done=%b ready=%b expected 0 1", c, done8, ready8);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            run_batch(8, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
            run_batch(6, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
